// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// combinational-read RAM. Each access takes IDLE -> GRANT -> RESP, with
// round-robin choice when both requesters collide.
module mem_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  // Instruction-fetch port
  input  logic                     I_REQ,
  input  logic [ADDRESS_WIDTH-1:0] I_ADDR,
  output logic [DATA_WIDTH-1:0]    I_RDATA,
  output logic                     I_ACK,
  // Data port
  input  logic                     D_REQ,
  input  logic                     D_WE,
  input  logic [ADDRESS_WIDTH-1:0] D_ADDR,
  input  logic [DATA_WIDTH-1:0]    D_WDATA,
  input  logic [1:0]               D_SEL,
  output logic [DATA_WIDTH-1:0]    D_RDATA,
  output logic                     D_ACK,
  // RAM side
  output logic [ADDRESS_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0]    RAM_DATA,
  output logic                     RAM_W_EN,
  output logic [1:0]               RAM_SEL,
  input  logic [DATA_WIDTH-1:0]    RAM_RDATA,
  output logic                     BUSY
);

  typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

  state_e state_q, state_d;

  // Source encoding: 1'b0 = fetch, 1'b1 = data.
  logic                     last_grant_q;
  logic                     src_q;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [1:0]               sel_q;
  logic [DATA_WIDTH-1:0]    i_rdata_q;
  logic [DATA_WIDTH-1:0]    d_rdata_q;

  logic latch_en;
  logic grant_data;

  // Data wins when it is the only requester, or on a collision when fetch had the last grant.
  assign grant_data = D_REQ & (~I_REQ | ~last_grant_q);

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (I_REQ || D_REQ) begin
          state_d  = StGrant;
          latch_en = 1'b1;
        end
      end
      StGrant: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning request's fields at the grant edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_q <= 1'b0;
      src_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= 2'b00;
    end else if (latch_en) begin
      last_grant_q <= grant_data;
      src_q        <= grant_data;
      we_q         <= grant_data & D_WE;
      addr_q       <= grant_data ? D_ADDR : I_ADDR;
      wdata_q      <= D_WDATA;
      sel_q        <= grant_data ? D_SEL : 2'b00;
    end
  end

  // Capture RAM read data on leaving GRANT; stores leave D_RDATA alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (state_q == StGrant) begin
      if (!src_q) begin
        i_rdata_q <= RAM_RDATA;
      end else if (!we_q) begin
        d_rdata_q <= RAM_RDATA;
      end
    end
  end

  // Outputs decoded from state; reset forces them low immediately.
  always_comb begin
    RAM_ADDR = addr_q;
    RAM_DATA = wdata_q;
    RAM_SEL  = sel_q;
    RAM_W_EN = (state_q == StGrant) && we_q;
    I_ACK    = (state_q == StResp) && !src_q;
    D_ACK    = (state_q == StResp) && src_q;
    BUSY     = (state_q != StIdle);
    I_RDATA  = i_rdata_q;
    D_RDATA  = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          I_REQ, D_REQ, D_WE;
  logic [AW-1:0] I_ADDR, D_ADDR, RAM_ADDR;
  logic [DW-1:0] D_WDATA, I_RDATA, D_RDATA, RAM_DATA, RAM_RDATA;
  logic [1:0]    D_SEL, RAM_SEL;
  logic          I_ACK, D_ACK, RAM_W_EN, BUSY;

  mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_SEL(D_SEL),
    .D_RDATA(D_RDATA), .D_ACK(D_ACK),
    .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_W_EN(RAM_W_EN), .RAM_SEL(RAM_SEL),
    .RAM_RDATA(RAM_RDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Bench RAM (word-indexed by address bits [9:2]), plus the model's own copy.
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  assign RAM_RDATA = mem[RAM_ADDR[9:2]];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding transaction, m_cnt cycles left until IDLE.
  int            m_cnt;
  logic          m_data, m_last_data, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, exp_i, exp_d;
  logic [1:0]    m_sel;

  logic ack_log[$];
  int   busy_cycles, wen_cycles, dack_cycles, iack_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_data = 1'b0; m_last_data = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_sel = 2'b00; exp_i = '0; exp_d = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic [7:0] idx;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 1) begin
        idx = m_addr[9:2];
        if (!m_data)    exp_i = ref_mem[idx];
        else if (!m_we) exp_d = ref_mem[idx];
        else            ref_mem[idx] = m_wdata;
      end
    end else if (I_REQ || D_REQ) begin
      m_data      = D_REQ && (!I_REQ || !m_last_data);
      m_last_data = m_data;
      m_addr      = m_data ? D_ADDR : I_ADDR;
      m_we        = m_data && D_WE;
      m_wdata     = D_WDATA;
      m_sel       = m_data ? D_SEL : 2'b00;
      m_cnt       = 2;
    end
  endtask

  task automatic check_outputs();
    check("busy",    64'(BUSY),     64'(m_cnt > 0));
    check("ram_wen", 64'(RAM_W_EN), 64'(m_cnt == 2 && m_we));
    check("i_ack",   64'(I_ACK),    64'(m_cnt == 1 && !m_data));
    check("d_ack",   64'(D_ACK),    64'(m_cnt == 1 && m_data));
    check("i_rdata", 64'(I_RDATA),  64'(exp_i));
    check("d_rdata", 64'(D_RDATA),  64'(exp_d));
    if (m_cnt > 0) begin
      check("ram_addr", 64'(RAM_ADDR), 64'(m_addr));
      check("ram_sel",  64'(RAM_SEL),  64'(m_sel));
      if (m_we) check("ram_data", 64'(RAM_DATA), 64'(m_wdata));
    end
    if (I_ACK) ack_log.push_back(1'b0);
    if (D_ACK) ack_log.push_back(1'b1);
    if (BUSY) busy_cycles++;
    if (RAM_W_EN) wen_cycles++;
    if (D_ACK) dack_cycles++;
    if (I_ACK) iack_cycles++;
  endtask

  // One clock cycle: check at the falling edge, drive, then let the edge pass.
  task automatic cycle(input logic ireq, input logic [AW-1:0] iaddr, input logic dreq,
                       input logic dwe, input logic [AW-1:0] daddr,
                       input logic [DW-1:0] dwdata, input logic [1:0] dsel);
    logic          wen;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    check_outputs();
    I_REQ = ireq; I_ADDR = iaddr; D_REQ = dreq; D_WE = dwe;
    D_ADDR = daddr; D_WDATA = dwdata; D_SEL = dsel;
    model_step();
    wen = RAM_W_EN; wa = RAM_ADDR; wd = RAM_DATA;
    @(posedge CLK);
    #1;
    if (wen) mem[wa[9:2]] = wd;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 2'b00);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("rst_busy",  64'(BUSY),     64'd0);
    check("rst_wen",   64'(RAM_W_EN), 64'd0);
    check("rst_acks",  64'({I_ACK, D_ACK}), 64'd0);
    check("rst_rdata", 64'({I_RDATA, D_RDATA}), 64'd0);
    check("rst_addr",  64'(RAM_ADDR), 64'd0);
    check("rst_wdata", 64'(RAM_DATA), 64'd0);
    check("rst_sel",   64'(RAM_SEL),  64'd0);
    model_reset();
    I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
    I_ADDR = '0; D_ADDR = '0; D_WDATA = '0; D_SEL = 2'b00;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
    I_ADDR = '0; D_ADDR = '0; D_WDATA = '0; D_SEL = 2'b00;
    for (int k = 0; k < 256; k++) begin
      mem[k]     = $urandom;
      ref_mem[k] = mem[k];
    end
    mem[0] = 32'h2008_0005;
    ref_mem[0] = 32'h2008_0005;
    model_reset();
    @(negedge CLK);
    do_reset();
    idle(2);

    // Single fetch from address 0, request held one cycle.
    wen_cycles = 0; iack_cycles = 0;
    cycle(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 2'b00);
    idle(4);
    check("fetch_rdata", 64'(I_RDATA), 64'h2008_0005);
    check("fetch_nowen", 64'(wen_cycles), 64'd0);
    check("fetch_iacks", 64'(iack_cycles), 64'd1);

    // Store then load at 0x100; the store request drops after one cycle.
    wen_cycles = 0; dack_cycles = 0; busy_cycles = 0;
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10);
    idle(4);
    check("store_wen1",  64'(wen_cycles), 64'd1);
    check("store_dack1", 64'(dack_cycles), 64'd1);
    check("store_busy2", 64'(busy_cycles), 64'd2);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b10);
    idle(4);
    check("load_rdata", 64'(D_RDATA), 64'hDEAD_BEEF);

    // Both requesters held high straight out of reset: data goes first, then alternate.
    do_reset();
    ack_log.delete();
    for (int k = 0; k < 14; k++)
      cycle(1'b1, 32'(k * 4), 1'b1, 1'b0, 32'(k * 8), 32'(k), 2'b01);
    idle(4);
    check("conf_nacks", 64'(ack_log.size() >= 4), 64'd1);
    if (ack_log.size() >= 4)
      check("conf_order", 64'({ack_log[0], ack_log[1], ack_log[2], ack_log[3]}), 64'b1010);

    // Reset in the middle of a store's GRANT cycle aborts it.
    idle(1);
    dack_cycles = 0;
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 2'b11);
    check_outputs();
    do_reset();
    idle(4);
    check("abort_nodack", 64'(dack_cycles), 64'd0);
    check("abort_mem", 64'(mem[8'h80]), 64'(ref_mem[8'h80]));
    cycle(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 2'b00);
    idle(4);
    check("abort_fetch", 64'(I_RDATA), 64'h2008_0005);

    // Fetch request stuck high with a moving address.
    iack_cycles = 0;
    for (int k = 0; k < 9; k++) cycle(1'b1, 32'($urandom), 1'b0, 1'b0, '0, '0, 2'b00);
    idle(4);
    check("held_iacks", 64'(iack_cycles), 64'd3);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom), 32'($urandom), 1'($urandom), 1'($urandom), 32'($urandom),
            32'($urandom), 2'($urandom));
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
